// File: rtl/muldiv_sequencer_if.sv
// Start/operand and result bundle between the CPU control unit and the iterative mul/div unit.
interface muldiv_sequencer_if #(parameter int WIDTH = 32);
    logic             mult_start;
    logic             div_start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic             divzero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output mult_start, div_start, op_a, op_b,
                    input  busy, done, divzero, hi, lo);
    modport slave  (input  mult_start, div_start, op_a, op_b,
                    output busy, done, divzero, hi, lo);
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative signed Booth multiply / restoring divide producing HI/LO; done after WIDTH (mult) or WIDTH+1 (div) cycles.
// No backpressure: starts are accepted only in IDLE and ignored while busy, never queued.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    muldiv_sequencer_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {IDLE, MULT, DIV, FIX, DONE, DZ} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [2*WIDTH:0] acc;
    logic [WIDTH-1:0] opnd_m;
    logic [WIDTH-1:0] quo, rem;
    logic             neg_q, neg_r;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             busy_q, done_q, dz_q;

    logic             last;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   booth_sum;
    logic [2*WIDTH:0] booth_next;
    logic [WIDTH:0]   div_shift, div_diff;

    assign last  = (cnt == CW'(WIDTH - 1));
    assign abs_a = bus.op_a[WIDTH-1] ? -bus.op_a : bus.op_a;
    assign abs_b = bus.op_b[WIDTH-1] ? -bus.op_b : bus.op_b;

    // Booth add/sub is done one bit wider so a most-negative multiplicand cannot overflow.
    always_comb begin
        booth_sum = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]};
        case (acc[1:0])
            2'b01:   booth_sum = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]} + {opnd_m[WIDTH-1], opnd_m};
            2'b10:   booth_sum = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]} - {opnd_m[WIDTH-1], opnd_m};
            default: ;
        endcase
        booth_next = {booth_sum, acc[WIDTH:1]};
    end

    // Partial remainder stays below the divisor, so the top bit of the difference is a clean sign.
    assign div_shift = {rem, quo[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd_m};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.mult_start)
                    state_nxt = MULT;
                else if (bus.div_start)
                    state_nxt = (bus.op_b == '0) ? DZ : DIV;
            end
            MULT:    if (last) state_nxt = DONE;
            DIV:     if (last) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            DZ:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            dz_q   <= 1'b0;
        end else begin
            state  <= state_nxt;
            busy_q <= (state_nxt != IDLE);
            done_q <= (state_nxt == DONE) || (state_nxt == DZ);
            dz_q   <= (state_nxt == DZ);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            acc    <= '0;
            opnd_m <= '0;
            quo    <= '0;
            rem    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (state_nxt == MULT) begin
                        opnd_m <= bus.op_a;
                        acc    <= {{WIDTH{1'b0}}, bus.op_b, 1'b0};
                    end else if (state_nxt == DIV) begin
                        opnd_m <= abs_b;
                        quo    <= abs_a;
                        rem    <= '0;
                        neg_q  <= bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1];
                        neg_r  <= bus.op_a[WIDTH-1];
                    end
                end
                MULT: begin
                    cnt <= cnt + 1'b1;
                    acc <= booth_next;
                    if (last) begin
                        hi_q <= booth_next[2*WIDTH:WIDTH+1];
                        lo_q <= booth_next[WIDTH:1];
                    end
                end
                DIV: begin
                    cnt <= cnt + 1'b1;
                    if (!div_diff[WIDTH]) begin
                        rem <= div_diff[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b1};
                    end else begin
                        rem <= div_shift[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b0};
                    end
                end
                FIX: begin
                    hi_q <= neg_r ? -rem : rem;
                    lo_q <= neg_q ? -quo : quo;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.divzero = dz_q;
    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized self-checking bench for muldiv_sequencer against a plain-arithmetic reference.
module tb_muldiv_sequencer;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    muldiv_sequencer_if #(.WIDTH(W)) bus();
    muldiv_sequencer #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_hi, exp_lo;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // kind 0: multiply, 1: divide (nonzero divisor); result packed as {hi, lo}
    function automatic logic [63:0] ref_result(input int kind, input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [63:0] sa, sb, q, r, p;
        sa = {{(64-W){a[W-1]}}, a};
        sb = {{(64-W){b[W-1]}}, b};
        if (kind == 1) begin
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
        end
        p = sa * sb;
        return p;
    endfunction

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    // kind 0: mult_start, 1: div_start, 2: both together
    task automatic run_op(input string tag, input int kind, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int poke, input bit poke_done);
        int n, lat, busy_hi, stray;
        logic [63:0] r;
        bit dz;
        dz  = (kind == 1) && (b == '0);
        lat = dz ? 0 : ((kind == 1) ? W + 1 : W);
        if (!dz) begin
            r = ref_result((kind == 1) ? 1 : 0, a, b);
            exp_hi = r[63:32];
            exp_lo = r[31:0];
        end
        bus.op_a = a;
        bus.op_b = b;
        bus.mult_start = (kind != 1);
        bus.div_start  = (kind != 0);
        tick();
        bus.mult_start = 1'b0;
        bus.div_start  = 1'b0;
        bus.op_a = $urandom;
        bus.op_b = $urandom;
        n = 0;
        busy_hi = 0;
        stray = 0;
        while (!bus.done && n <= W + 5) begin
            if (bus.busy) busy_hi++;
            if (bus.divzero) stray++;
            if (n == poke) begin
                bus.div_start  = 1'b1;
                bus.mult_start = 1'($urandom_range(0, 1));
            end
            tick();
            bus.div_start  = 1'b0;
            bus.mult_start = 1'b0;
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'(lat));
        check({tag, " busy_cycles"}, 64'(busy_hi + int'(bus.busy)), 64'(lat + 1));
        check({tag, " divzero"}, 64'(bus.divzero), 64'(dz));
        check({tag, " stray_divzero"}, 64'(stray), 64'd0);
        check({tag, " hi"}, 64'(bus.hi), 64'(exp_hi));
        check({tag, " lo"}, 64'(bus.lo), 64'(exp_lo));
        if (poke_done) begin
            bus.div_start  = 1'b1;
            bus.mult_start = 1'b1;
            bus.op_b = '0;
        end
        tick();
        bus.div_start  = 1'b0;
        bus.mult_start = 1'b0;
        check({tag, " idle_flags"}, 64'({bus.busy, bus.done, bus.divzero}), 64'd0);
        check({tag, " hold"}, {bus.hi, bus.lo}, {exp_hi, exp_lo});
    endtask

    initial begin
        int dones;
        reset = 1'b1;
        bus.mult_start = 1'b0;
        bus.div_start  = 1'b0;
        bus.op_a = '0;
        bus.op_b = '0;
        exp_hi = '0;
        exp_lo = '0;
        repeat (3) tick();
        check("reset flags", 64'({bus.busy, bus.done, bus.divzero}), 64'd0);
        check("reset hilo", {bus.hi, bus.lo}, 64'd0);
        reset = 1'b0;
        tick();
        check("post_reset flags", 64'({bus.busy, bus.done, bus.divzero}), 64'd0);

        run_op("mul_7x-3",     0, 32'd7,          32'hFFFF_FFFD, -1, 1'b0);
        run_op("mul_min_min",  0, 32'h8000_0000,  32'h8000_0000, -1, 1'b0);
        run_op("div_-7/2",     1, 32'hFFFF_FFF9,  32'd2,         -1, 1'b0);
        run_op("div_zero",     1, 32'd5,          32'd0,         -1, 1'b0);
        run_op("both_5_3",     2, 32'd5,          32'd3,         10, 1'b0);
        run_op("div_min/-1",   1, 32'h8000_0000,  32'hFFFF_FFFF, -1, 1'b1);
        run_op("div_7/-2",     1, 32'd7,          32'hFFFF_FFFE, 3,  1'b0);

        // Reset in the middle of a divide aborts it and clears the results.
        bus.op_a = 32'd100;
        bus.op_b = 32'd7;
        bus.div_start = 1'b1;
        tick();
        bus.div_start = 1'b0;
        repeat (14) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort busy", 64'(bus.busy), 64'd0);
        check("abort hilo", {bus.hi, bus.lo}, 64'd0);
        exp_hi = '0;
        exp_lo = '0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) dones++;
            tick();
        end
        check("abort no_done", 64'(dones), 64'd0);
        run_op("mul_6x7", 0, 32'd6, 32'd7, -1, 1'b0);

        for (int i = 0; i < 40; i++) begin
            int k, p;
            logic [W-1:0] a, b;
            k = int'($urandom_range(0, 2));
            a = pick_operand();
            b = pick_operand();
            p = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W - 1)) : -1;
            run_op($sformatf("rand%0d", i), k, a, b, p, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
